// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, qualified-stability debounce FSM, and
// registered level plus press/release strobes. Define AUTO_REPEAT_EN for held-key auto-repeat.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter bit KEY_ACTIVE_LOW  = 1'b1,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic key_state,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
   localparam int MAX_CNT = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
   localparam int CNT_W   = $clog2(MAX_CNT) + 1;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      PRESS_CHK   = 2'd1,
      HELD        = 2'd2,
      RELEASE_CHK = 2'd3
   } state_e;

   logic [1:0]       sync_q;
   logic             p_sync;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             key_state_q, key_state_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             rpt_fire;

   // Both flops reset to the released level so a reset never fakes a press.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep the two flops a true shift chain.
      if (rst) begin
         sync_q <= {2{KEY_ACTIVE_LOW}};
      end else begin
         sync_q <= {sync_q[0], key};
      end
   end

   assign p_sync = sync_q[1] ^ KEY_ACTIVE_LOW;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (p_sync) begin
               state_d = PRESS_CHK;
               cnt_d   = CNT_ONE;
            end
         end
         PRESS_CHK: begin
            if (!p_sync) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_TERM) begin
               state_d = HELD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         HELD: begin
            cnt_d = '0;
            if (!p_sync) begin
               state_d = RELEASE_CHK;
               cnt_d   = CNT_ONE;
            end
         end
         RELEASE_CHK: begin
            if (p_sync) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == CNT_TERM) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

`ifdef AUTO_REPEAT_EN
   logic [CNT_W-1:0] rpt_q, rpt_d;
   logic             rpt_arm_q, rpt_arm_d;

   // First strobe after REPEAT_DELAY held cycles, then every REPEAT_PERIOD.
   assign rpt_fire = (state_q == HELD) &&
                     (rpt_q == (rpt_arm_q ? CNT_W'(REPEAT_PERIOD) : CNT_W'(REPEAT_DELAY)));

   always_comb begin
      rpt_d     = rpt_q;
      rpt_arm_d = rpt_arm_q;
      if (state_q != HELD) begin
         rpt_d     = '0;
         rpt_arm_d = 1'b0;
      end else if (rpt_fire) begin
         rpt_d     = CNT_ONE;
         rpt_arm_d = 1'b1;
      end else begin
         rpt_d = rpt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rpt_q     <= '0;
         rpt_arm_q <= 1'b0;
      end else begin
         rpt_q     <= rpt_d;
         rpt_arm_q <= rpt_arm_d;
      end
   end
`else
   assign rpt_fire = 1'b0;
`endif

   // Strobes come from the registered level's edge, so they align with key_state.
   always_comb begin
      key_state_d = (state_q == HELD) || (state_q == RELEASE_CHK);
      press_d     = (key_state_d && !key_state_q) || rpt_fire;
      release_d   = !key_state_d && key_state_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_state_q <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
      end else begin
         key_state_q <= key_state_d;
         press_q     <= press_d;
         release_q   <= release_d;
      end
   end

   assign key_state     = key_state_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;

endmodule
